mst_arbiter: RTL and testbench

Packet-atomic two-source arbiter in front of the shared 18-bit master FIFO. Source 0 is the UDP server write path; source 1 is a second requester, such as a local register or DMA engine. Both sources present framed words, and the arbiter merges them round-robin without ever interleaving words of different packets. It also drops mis-framed words and aborts packets whose source stalls mid-burst.

---
 rtl/mst_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mst_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mst_arbiter.sv
// mst_arbiter: packet-atomic round-robin merge of two framed FWFT sources
// into the shared 18-bit master FIFO.
// Word tag in [17:16]: 10 start, 00 middle, 01 end, 11 single-word packet.
// Mis-framed heads are dropped while idle. A granted packet whose source
// stalls for TIMEOUT_CYC cycles is closed with a synthetic end word.
// Optional feature macro: MST_ARB_STAT_EN enables the pkt_cnt0/pkt_cnt1/
// drop_cnt statistics counters. Without it, those outputs are tied to zero.
module mst_arbiter #(
    parameter logic [11:0] TIMEOUT_CYC = 12'd1024
) (
    input  logic        pcie_clk,
    input  logic        sys_rst_n,
    input  logic [17:0] src0_dout,
    input  logic        src0_empty,
    output logic        src0_rd_en,
    input  logic [17:0] src1_dout,
    input  logic        src1_empty,
    output logic        src1_rd_en,
    output logic [17:0] mst_din,
    input  logic        mst_full,
    output logic        mst_wr_en,
    output logic [1:0]  grant,
    output logic        err_drop,
    output logic        err_wdog,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant_nxt;
    logic        last_grant, lg_nxt;
    logic [11:0] wdog, wdog_nxt;
    logic        wr_nxt;
    logic [17:0] din_nxt;
    logic        set_drop, set_wdog;

    // Head classification: bit 17 marks a packet start, bit 16 a packet end
    logic req0, req1, bad0, bad1;
    assign req0 = ~src0_empty &  src0_dout[17];
    assign req1 = ~src1_empty &  src1_dout[17];
    assign bad0 = ~src0_empty & ~src0_dout[17];
    assign bad1 = ~src1_empty & ~src1_dout[17];

    // Selected source view while a packet is granted
    logic        gsel, pop;
    logic [17:0] head;
    logic        head_empty;
    assign gsel       = (state == GNT1);
    assign head       = gsel ? src1_dout  : src0_dout;
    assign head_empty = gsel ? src1_empty : src0_empty;

    // State register and registered master-FIFO write port
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            wdog       <= 12'd0;
            mst_wr_en  <= 1'b0;
            mst_din    <= 18'd0;
            err_drop   <= 1'b0;
            err_wdog   <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= lg_nxt;
            wdog       <= wdog_nxt;
            mst_wr_en  <= wr_nxt;
            mst_din    <= din_nxt;
            if (set_drop) err_drop <= 1'b1;
            if (set_wdog) err_wdog <= 1'b1;
        end
    end

    // Next-state, pops and write request; defaults hold everything idle
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        lg_nxt     = last_grant;
        wdog_nxt   = wdog;
        wr_nxt     = 1'b0;
        din_nxt    = mst_din;
        set_drop   = 1'b0;
        set_wdog   = 1'b0;
        pop        = 1'b0;
        src0_rd_en = 1'b0;
        src1_rd_en = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt = 2'b00;
                if (bad0 || bad1) begin
                    // One bad head per cycle, source 0 first; pops are
                    // withheld while full so rd_en never coincides with it
                    if (!mst_full) begin
                        set_drop   = 1'b1;
                        src0_rd_en = bad0;
                        src1_rd_en = ~bad0;
                    end
                end else if (req0 && (!req1 || last_grant)) begin
                    state_nxt = GNT0;
                    grant_nxt = 2'b01;
                    wdog_nxt  = 12'd0;
                end else if (req1) begin
                    state_nxt = GNT1;
                    grant_nxt = 2'b10;
                    wdog_nxt  = 12'd0;
                end
            end
            GNT0, GNT1: begin
                pop        = ~head_empty & ~mst_full;
                src0_rd_en = pop & ~gsel;
                src1_rd_en = pop &  gsel;
                if (pop) begin
                    wr_nxt   = 1'b1;
                    din_nxt  = head;
                    wdog_nxt = 12'd0;
                    if (head[16]) begin
                        state_nxt = IDLE;
                        grant_nxt = 2'b00;
                        lg_nxt    = gsel;
                    end
                end else if (wdog == TIMEOUT_CYC - 12'd1) begin
                    state_nxt = ABORT;
                end else begin
                    wdog_nxt = wdog + 12'd1;
                end
            end
            ABORT: begin
                // Close the stalled packet with an empty end word
                if (!mst_full) begin
                    wr_nxt    = 1'b1;
                    din_nxt   = {2'b01, 16'h0000};
                    set_wdog  = 1'b1;
                    lg_nxt    = grant[1];
                    grant_nxt = 2'b00;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MST_ARB_STAT_EN
    logic inc_pkt0, inc_pkt1, inc_drop;
    assign inc_pkt0 = (state == GNT0) & src0_rd_en & src0_dout[16];
    assign inc_pkt1 = (state == GNT1) & src1_rd_en & src1_dout[16];
    assign inc_drop = (state == IDLE) & (src0_rd_en | src1_rd_en);

    // Statistics counters, free-running modulo 2^16
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_cnt0 <= 16'h0000;
            pkt_cnt1 <= 16'h0000;
            drop_cnt <= 16'h0000;
        end else begin
            if (inc_pkt0) pkt_cnt0 <= pkt_cnt0 + 16'h0001;
            if (inc_pkt1) pkt_cnt1 <= pkt_cnt1 + 16'h0001;
            if (inc_drop) drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`else
    assign pkt_cnt0 = 16'h0000;
    assign pkt_cnt1 = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mst_arbiter.sv
// tb_mst_arbiter: table-driven cycle checks, directed corner sequences and a
// randomized run scored against per-source expected word streams.
module tb_mst_arbiter;

    localparam logic [11:0] TO = 12'd1024;
`ifdef MST_ARB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        pcie_clk = 1'b0;
    logic        sys_rst_n;
    logic [17:0] src0_dout, src1_dout, mst_din;
    logic        src0_empty, src1_empty, src0_rd_en, src1_rd_en;
    logic        mst_full, mst_wr_en, err_drop, err_wdog;
    logic [1:0]  grant;
    logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;

    always #5 pcie_clk = ~pcie_clk;

    mst_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n),
        .src0_dout(src0_dout), .src0_empty(src0_empty), .src0_rd_en(src0_rd_en),
        .src1_dout(src1_dout), .src1_empty(src1_empty), .src1_rd_en(src1_rd_en),
        .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
        .grant(grant), .err_drop(err_drop), .err_wdog(err_wdog),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] q0[$], q1[$];
    logic        gate0, gate1;
    logic        s_rd0, s_rd1, s_wr;
    logic [17:0] s_din;
    logic [1:0]  s_grant;
    logic        popped;
    logic [17:0] pop_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present FWFT heads of the modelled source FIFOs
    task automatic drive();
        src0_dout  = (q0.size() > 0) ? q0[0] : 18'd0;
        src1_dout  = (q1.size() > 0) ? q1[0] : 18'd0;
        src0_empty = gate0 || (q0.size() == 0);
        src1_empty = gate1 || (q1.size() == 0);
    endtask

    // One clock: sample at negedge, apply pops just after posedge
    task automatic cycle();
        @(negedge pcie_clk);
        s_rd0 = src0_rd_en; s_rd1 = src1_rd_en;
        s_wr = mst_wr_en; s_din = mst_din; s_grant = grant;
        chk("no_rd_while_full", (s_rd0 | s_rd1) & mst_full, 0);
        chk("no_rd_while_empty", (s_rd0 & src0_empty) | (s_rd1 & src1_empty), 0);
        chk("single_pop", s_rd0 & s_rd1, 0);
        @(posedge pcie_clk);
        #1;
        popped = s_rd0 | s_rd1;
        if (s_rd0 && q0.size() > 0) pop_w = q0.pop_front();
        else if (s_rd1 && q1.size() > 0) pop_w = q1.pop_front();
        drive();
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        gate0 = 0; gate1 = 0; mst_full = 0; popped = 0; pop_w = '0;
        drive();
        sys_rst_n = 0;
        @(posedge pcie_clk);
        #1;
        sys_rst_n = 1;
    endtask

    typedef struct {
        logic        full;
        logic        rd0;
        logic        wr;
        logic [17:0] din;
        logic [1:0]  gnt;
    } vec_t;
    vec_t tv[17];

    logic [17:0] wd[$];
    int          wc[$];
    logic [17:0] exp_ord[$];
    logic [17:0] exp0[$], exp1[$];

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            mst_full = tv[i].full;
            drive();
            cycle();
            chk($sformatf("vec%0d_rd0", i), s_rd0, tv[i].rd0);
            chk($sformatf("vec%0d_wr", i), s_wr, tv[i].wr);
            chk($sformatf("vec%0d_din", i), s_din, tv[i].din);
            chk($sformatf("vec%0d_grant", i), s_grant, tv[i].gnt);
        end
    endtask

    initial begin
        int abort_at, nw, cyc, bubble, cur, s, len;
        logic in_pkt, exp_wr;
        logic [17:0] exp_w, e;
        logic [1:0] tag;

        // Single packet from source 0, then mst_full held 5 cycles mid-packet
        tv[0]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 2'b00};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 2'b01};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 18'h28140, 2'b01};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 18'h01234, 2'b01};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 18'h1BEEF, 2'b00};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 18'h1BEEF, 2'b00};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 18'h00000, 2'b00};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 2'b01};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 18'h20001, 2'b01};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 18'h20001, 2'b01};
        tv[10] = '{1'b1, 1'b0, 1'b0, 18'h20001, 2'b01};
        tv[11] = '{1'b1, 1'b0, 1'b0, 18'h20001, 2'b01};
        tv[12] = '{1'b1, 1'b0, 1'b0, 18'h20001, 2'b01};
        tv[13] = '{1'b0, 1'b1, 1'b0, 18'h20001, 2'b01};
        tv[14] = '{1'b0, 1'b1, 1'b1, 18'h00002, 2'b01};
        tv[15] = '{1'b0, 1'b0, 1'b1, 18'h10003, 2'b00};
        tv[16] = '{1'b0, 1'b0, 1'b0, 18'h10003, 2'b00};

        // Reset state
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_wr_en", mst_wr_en, 0);
        chk("rst_din", mst_din, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_err_wdog", err_wdog, 0);
        chk("rst_pkt_cnt0", pkt_cnt0, 0);
        chk("rst_drop_cnt", drop_cnt, 0);

        q0.push_back(18'h28140); q0.push_back(18'h01234); q0.push_back(18'h1BEEF);
        drive();
        run_vec(0, 5);
        chk("pkt_cnt0_after_one", pkt_cnt0, STAT ? 32'd1 : 32'd0);
        chk("pkt_cnt1_after_one", pkt_cnt1, 0);

        do_reset();
        q0.push_back(18'h20001); q0.push_back(18'h00002); q0.push_back(18'h10003);
        drive();
        run_vec(6, 16);

        // Simultaneous requests: round-robin packet order, one bubble between
        do_reset();
        exp_ord.delete(); wd.delete(); wc.delete();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                tag = (k == 0) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
                q0.push_back({tag, 16'h0010 + 16'(p * 3 + k)});
                q1.push_back({tag, 16'h8020 + 16'(p * 3 + k)});
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) exp_ord.push_back(q0[p * 3 + k]);
            for (int k = 0; k < 3; k++) exp_ord.push_back(q1[p * 3 + k]);
        end
        drive();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_wr) begin wd.push_back(s_din); wc.push_back(i); end
        end
        chk("rr_word_count", wd.size(), 12);
        for (int i = 0; i < 12 && i < wd.size(); i++) begin
            chk($sformatf("rr_word%0d", i), wd[i], exp_ord[i]);
            if (i > 0) chk($sformatf("rr_gap%0d", i), wc[i] - wc[i-1], (i % 3 == 0) ? 2 : 1);
        end
        chk("rr_pkt_cnt1", pkt_cnt1, STAT ? 32'd2 : 32'd0);

        // Bad head on source 1 is dropped, then its packet goes through
        do_reset();
        q1.push_back(18'h0AAAA); q1.push_back(18'h2B001); q1.push_back(18'h1B002);
        drive();
        cycle();
        chk("drop_pop", s_rd1, 1);
        cycle();
        chk("drop_no_write", s_wr, 0);
        chk("drop_err", err_drop, 1);
        chk("drop_cnt", drop_cnt, STAT ? 32'd1 : 32'd0);
        wd.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_wr) wd.push_back(s_din);
        end
        chk("drop_fwd_count", wd.size(), 2);
        if (wd.size() == 2) begin
            chk("drop_fwd_start", wd[0], 18'h2B001);
            chk("drop_fwd_end", wd[1], 18'h1B002);
        end

        // Watchdog: start word then a long stall
        do_reset();
        q0.push_back(18'h20011);
        drive();
        abort_at = -1; nw = 0;
        for (int i = 0; i < int'(TO) + 20 && abort_at < 0; i++) begin
            cycle();
            if (s_wr) begin
                if (s_din == 18'h10000) abort_at = i;
                else nw++;
            end
        end
        chk("wdog_abort_seen", abort_at >= 0, 1);
        chk("wdog_window", (abort_at >= int'(TO)) && (abort_at <= int'(TO) + 4), 1);
        chk("wdog_only_start", nw, 1);
        chk("wdog_err", err_wdog, 1);
        chk("wdog_grant_idle", grant, 0);
        q0.push_back(18'h00012); q0.push_back(18'h10013);
        drive();
        nw = 0;
        for (int i = 0; i < 6; i++) begin cycle(); if (s_wr) nw++; end
        chk("late_words_not_written", nw, 0);
        chk("late_words_drained", q0.size(), 0);
        chk("late_drop_cnt", drop_cnt, STAT ? 32'd2 : 32'd0);
        chk("late_err_drop", err_drop, 1);

        // Asynchronous reset in the middle of a packet
        do_reset();
        q0.push_back(18'h20041); q0.push_back(18'h00042); q0.push_back(18'h00043);
        q0.push_back(18'h00044); q0.push_back(18'h10045);
        drive();
        for (int i = 0; i < 3; i++) cycle();
        #2;
        sys_rst_n = 0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_wr_en", mst_wr_en, 0);
        chk("arst_din", mst_din, 0);
        chk("arst_err_wdog", err_wdog, 0);
        q0.delete();
        drive();
        @(posedge pcie_clk);
        #1;
        sys_rst_n = 1;
        q0.push_back(18'h30099);
        drive();
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_wr) begin nw++; chk("arst_new_word", s_din, 18'h30099); end
        end
        chk("arst_new_count", nw, 1);
        chk("arst_pkt_cnt0", pkt_cnt0, STAT ? 32'd1 : 32'd0);

        // Randomized traffic against per-source expected streams
        do_reset();
        exp0.delete(); exp1.delete();
        for (int src = 0; src < 2; src++) begin
            for (int p = 0; p < 25; p++) begin
                len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++) begin
                    tag = (len == 1) ? 2'b11 : (k == 0) ? 2'b10 : (k == len - 1) ? 2'b01 : 2'b00;
                    e = {tag, src[0], 15'($urandom)};
                    if (src == 0) begin q0.push_back(e); exp0.push_back(e); end
                    else begin q1.push_back(e); exp1.push_back(e); end
                end
            end
        end
        in_pkt = 0; cur = 0; bubble = 0; cyc = 0;
        while ((exp0.size() > 0 || exp1.size() > 0) && cyc < 4000) begin
            gate0 = ($urandom_range(0, 3) == 0);
            gate1 = ($urandom_range(0, 3) == 0);
            mst_full = ($urandom_range(0, 4) == 0);
            drive();
            exp_wr = popped; exp_w = pop_w;
            cycle();
            cyc++;
            chk("rnd_latency", s_wr, exp_wr);
            if (bubble) chk("rnd_bubble", s_wr, 0);
            bubble = 0;
            if (s_wr) begin
                chk("rnd_pop_data", s_din, exp_w);
                s = int'(s_din[15]);
                if (in_pkt) chk("rnd_no_interleave", s, cur);
                if (s == 0 && exp0.size() > 0) chk("rnd_src0_order", s_din, exp0.pop_front());
                else if (s == 1 && exp1.size() > 0) chk("rnd_src1_order", s_din, exp1.pop_front());
                else chk("rnd_unexpected_word", s_din, 18'h3FFFF ^ s_din);
                if (s_din[16]) begin in_pkt = 0; bubble = 1; end
                else if (s_din[17]) begin in_pkt = 1; cur = s; end
            end
        end
        chk("rnd_drained", exp0.size() + exp1.size(), 0);
        chk("rnd_pkt_cnt0", pkt_cnt0, STAT ? 32'd25 : 32'd0);
        chk("rnd_pkt_cnt1", pkt_cnt1, STAT ? 32'd25 : 32'd0);
        chk("rnd_no_errors", {err_drop, err_wdog}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
